led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
Parametrised LED pattern engine driving an N-wide LED bank from a single board clock. A programmable prescaler produces step ticks. A pattern sequencer advances on each tick in one of four modes: chase up, chase down, bounce, or blink-all. It replaces fixed single-mode chasers in board bring-up designs and drives the LED and LED-enable pads directly.

Parameters:
NUM_LEDS, 5, LED count; legal range 2..32
BASE_DIV, 5_000_000, prescaler base period in clk cycles; must be >= 1
SPEED_W, 3, width of speed select
PWM_W, 8, brightness/PWM counter width; used only with LED_PWM_DIM_EN

Ports:
clk  input  1  board clock
rst  input  1  asynchronous, active-high reset
run  input  1  1 = prescaler counts, 0 = pattern frozen
mode  input  2  0 CHASE_UP, 1 CHASE_DOWN, 2 BOUNCE, 3 BLINK_ALL
speed  input  SPEED_W  step period = BASE_DIV*(speed+1) cycles
brightness  input  PWM_W  duty select; present only with LED_PWM_DIM_EN
LED  output  NUM_LEDS  LED drive, registered
LED_en  output  NUM_LEDS  constant all-ones
clk_en  output  1  constant 1
step_pulse  output  1  one-cycle strobe, registered, coincident with LED update

Behaviour:
- Reset (async assert, sync use after release): cnt=0, ptr=0, dir=UP, phase=0, step_pulse=0, LED = one-hot bit 0 (1 in LSB).
- Prescaler: cnt is 32-bit, limit = BASE_DIV*(speed+1), computed at 32 bits.
  - run=1: if cnt >= limit-1, raise tick and set cnt=0; else cnt+1.
  - The >= compare means a speed decrease with cnt already past the new limit ticks on the next cycle, never after a wrap.
  - run=0: cnt holds and tick=0.
- On tick, the sequencer updates according to the mode sampled that cycle:
  - CHASE_UP: ptr = (ptr==N-1) ? 0 : ptr+1.
  - CHASE_DOWN: ptr = (ptr==0) ? N-1 : ptr-1.
  - BOUNCE: step ptr in dir. At ptr==N-1 with dir UP, set dir=DOWN and ptr=N-2. At ptr==0 with dir DOWN, set dir=UP and ptr=1. Ends are not repeated.
  - BLINK_ALL: phase toggles; ptr and dir hold.
- Mode change: takes effect at the next tick; no reset of ptr. Entering BOUNCE from another mode forces dir=UP, or DOWN if ptr==N-1. phase clears whenever mode != BLINK_ALL.
- Output: LED register loads in the cycle after the tick. Chase/bounce modes give one-hot LED[ptr]. BLINK_ALL gives all-ones if phase=1, else all-zeros. step_pulse=1 in that same cycle.
- Latency: tick to LED change is exactly 1 cycle.
- rst mid-step: all state returns to reset values immediately; no pending tick survives.

Optional Feature:
LED_PWM_DIM_EN
- Defined:
  - brightness port exists.
  - Free-running PWM_W-bit pwm_cnt, cleared by reset.
  - LED = pattern & {N{pwm_cnt < brightness}}, registered.
  - brightness=0 means LEDs always off; brightness=2^PWM_W-1 gives (2^PWM_W-1)/2^PWM_W duty.
  - step_pulse timing is unchanged.
- Undefined: no brightness port, no pwm_cnt, LED = pattern.

Decomposition:
- Package led_pattern_pkg holds:
  - mode enum (MODE_CHASE_UP, MODE_CHASE_DOWN, MODE_BOUNCE, MODE_BLINK_ALL)
  - dir enum (DIR_UP, DIR_DOWN)
  - PRESC_W=32 constant
- Sub-module tick_prescaler contains cnt/limit/run logic and outputs tick. It is reusable by other timer blocks.
- The sequencer and output register stay in the top module.

Test Plan:
1. NUM_LEDS=5, BASE_DIV=4, speed=0, mode=0, run=1 after reset -> LED 00001, then 00010 at cycle 5 after reset release, then 00100, 01000, 10000, 00001 every 4 cycles; step_pulse high the same cycles.
2. mode=2, speed=1 (8-cycle period) -> LED sequence 00001,00010,00100,01000,10000,01000,00100,00010,00001; no repeated endpoint.
3. mode=3 -> LED alternates 11111/00000 per tick. Switch to mode=1 mid-run -> next tick gives one-hot at ptr-1, wrapping 0->4.
4. run=0 for 20 cycles mid-period, then run=1 -> remaining cycles to tick preserved, no step_pulse while paused. speed 7->0 with cnt=10 -> tick on next cycle.
5. rst asserted asynchronously between clock edges during BOUNCE dir DOWN -> LED=00001, step_pulse=0 immediately. After release, the first tick gives 00010.
6. LED_PWM_DIM_EN, PWM_W=8, brightness=64 -> active LED high for exactly 64 of every 256 cycles. brightness=0 -> LED stays 0.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern engine and its prescaler.
// Imported by tick_prescaler and led_pattern_gen.
package led_pattern_pkg;

    localparam int PRESC_W = 32;

    typedef enum logic [1:0] {
        MODE_CHASE_UP   = 2'd0,
        MODE_CHASE_DOWN = 2'd1,
        MODE_BOUNCE     = 2'd2,
        MODE_BLINK_ALL  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Step period in clock cycles: base * (speed + 1), evaluated at prescaler width.
    function automatic logic [PRESC_W-1:0] calc_limit(
        input logic [PRESC_W-1:0] base,
        input logic [PRESC_W-1:0] speed
    );
        return base * (speed + PRESC_W'(1));
    endfunction

endpackage

// File: rtl/led_pattern_gen_tick_prescaler.sv
// Programmable tick prescaler: emits a registered one-cycle tick every
// BASE_DIV*(speed+1) running cycles; pauses (count held) while run is low.
module tick_prescaler
    import led_pattern_pkg::*;
#(
    parameter int BASE_DIV = 5_000_000,
    parameter int SPEED_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [SPEED_W-1:0] speed,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;
    logic [PRESC_W-1:0] limit_s;
    logic               tick_q;
    logic               tick_d;

    // Count toward the limit; >= lets a shortened period fire at once instead of wrapping.
    always_comb begin
        limit_s = calc_limit(PRESC_W'(BASE_DIV), PRESC_W'(speed));
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        if (run) begin
            if (cnt_q >= (limit_s - PRESC_W'(1))) begin
                cnt_d  = PRESC_W'(0);
                tick_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + PRESC_W'(1);
                tick_d = 1'b0;
            end
        end else begin
            cnt_d  = cnt_q;
            tick_d = 1'b0;
        end
    end

    // Counter and tick registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= PRESC_W'(0);
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern engine (chase up/down, bounce, blink-all).
// Optional LED_PWM_DIM_EN adds a brightness port and PWM dimming of the LED bank.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS = 5,
    parameter int BASE_DIV = 5_000_000,
    parameter int SPEED_W  = 3,
    parameter int PWM_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [1:0]          mode,
    input  logic [SPEED_W-1:0]  speed,
`ifdef LED_PWM_DIM_EN
    input  logic [PWM_W-1:0]    brightness,
`endif
    output logic [NUM_LEDS-1:0] LED,
    output logic [NUM_LEDS-1:0] LED_en,
    output logic                clk_en,
    output logic                step_pulse
);

    localparam int PTR_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [PTR_W-1:0]    PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0]    PTR_MAX  = PTR_W'(NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0] LED_ONE  = NUM_LEDS'(1);
    localparam logic [NUM_LEDS-1:0] LED_ALL  = {NUM_LEDS{1'b1}};
    localparam logic [NUM_LEDS-1:0] LED_NONE = {NUM_LEDS{1'b0}};

    logic                tick_s;
    mode_e               mode_s;
    dir_e                bounce_dir_s;
    logic [NUM_LEDS-1:0] pattern_cur_s;

    logic [PTR_W-1:0]    ptr_q,        ptr_d;
    dir_e                dir_q,        dir_d;
    logic                phase_q,      phase_d;
    mode_e               seq_mode_q,   seq_mode_d;
    logic                step_pulse_q, step_pulse_d;
    logic [NUM_LEDS-1:0] led_q,        led_d;
    logic [NUM_LEDS-1:0] pattern_d;

    tick_prescaler #(
        .BASE_DIV (BASE_DIV),
        .SPEED_W  (SPEED_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .speed (speed),
        .tick  (tick_s)
    );

    assign mode_s = mode_e'(mode);

    // Sequencer next state; seq_mode_q remembers the mode of the last step to detect BOUNCE entry.
    always_comb begin
        ptr_d        = ptr_q;
        dir_d        = dir_q;
        seq_mode_d   = seq_mode_q;
        bounce_dir_s = dir_q;
        if (mode_s != MODE_BLINK_ALL) begin
            phase_d = 1'b0;
        end else begin
            phase_d = phase_q;
        end
        if (tick_s) begin
            seq_mode_d = mode_s;
            case (mode_s)
                MODE_CHASE_UP: begin
                    ptr_d = (ptr_q == PTR_MAX) ? PTR_ZERO : ptr_q + PTR_ONE;
                end
                MODE_CHASE_DOWN: begin
                    ptr_d = (ptr_q == PTR_ZERO) ? PTR_MAX : ptr_q - PTR_ONE;
                end
                MODE_BOUNCE: begin
                    if (seq_mode_q != MODE_BOUNCE) begin
                        bounce_dir_s = (ptr_q == PTR_MAX) ? DIR_DOWN : DIR_UP;
                    end else begin
                        bounce_dir_s = dir_q;
                    end
                    if (bounce_dir_s == DIR_UP) begin
                        if (ptr_q == PTR_MAX) begin
                            dir_d = DIR_DOWN;
                            ptr_d = PTR_MAX - PTR_ONE;
                        end else begin
                            dir_d = DIR_UP;
                            ptr_d = ptr_q + PTR_ONE;
                        end
                    end else begin
                        if (ptr_q == PTR_ZERO) begin
                            dir_d = DIR_UP;
                            ptr_d = PTR_ONE;
                        end else begin
                            dir_d = DIR_DOWN;
                            ptr_d = ptr_q - PTR_ONE;
                        end
                    end
                end
                MODE_BLINK_ALL: begin
                    phase_d = ~phase_q;
                end
                default: begin
                    ptr_d = ptr_q;
                end
            endcase
        end else begin
            seq_mode_d = seq_mode_q;
        end
    end

    // Pattern loads only on a step; between steps the displayed pattern is held.
    always_comb begin
        step_pulse_d = tick_s;
        if (tick_s) begin
            if (mode_s == MODE_BLINK_ALL) begin
                pattern_d = phase_d ? LED_ALL : LED_NONE;
            end else begin
                pattern_d = LED_ONE << ptr_d;
            end
        end else begin
            pattern_d = pattern_cur_s;
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [PWM_W-1:0]    pwm_cnt_q;
    logic [NUM_LEDS-1:0] pattern_q;

    // The undimmed pattern needs its own register since LED is gated every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= PWM_W'(0);
            pattern_q <= LED_ONE;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
            pattern_q <= pattern_d;
        end
    end

    assign pattern_cur_s = pattern_q;
    assign led_d         = pattern_d & {NUM_LEDS{pwm_cnt_q < brightness}};
`else
    assign pattern_cur_s = led_q;
    assign led_d         = pattern_d;
`endif

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= PTR_ZERO;
            dir_q        <= DIR_UP;
            phase_q      <= 1'b0;
            seq_mode_q   <= MODE_CHASE_UP;
            step_pulse_q <= 1'b0;
            led_q        <= LED_ONE;
        end else begin
            ptr_q        <= ptr_d;
            dir_q        <= dir_d;
            phase_q      <= phase_d;
            seq_mode_q   <= seq_mode_d;
            step_pulse_q <= step_pulse_d;
            led_q        <= led_d;
        end
    end

    assign LED        = led_q;
    assign step_pulse = step_pulse_q;
    assign LED_en     = LED_ALL;
    assign clk_en     = 1'b1;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen (NUM_LEDS=5, BASE_DIV=4).
// With LED_PWM_DIM_EN defined it runs the reset and dimming scenarios.
module tb_led_pattern_gen;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         run;
    logic [1:0]   mode;
    logic [2:0]   speed;
`ifdef LED_PWM_DIM_EN
    logic [7:0]   brightness;
`endif
    logic [N-1:0] led;
    logic [N-1:0] led_en;
    logic         clk_en;
    logic         step_pulse;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .NUM_LEDS (N),
        .BASE_DIV (4),
        .SPEED_W  (3),
        .PWM_W    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .mode       (mode),
        .speed      (speed),
`ifdef LED_PWM_DIM_EN
        .brightness (brightness),
`endif
        .LED        (led),
        .LED_en     (led_en),
        .clk_en     (clk_en),
        .step_pulse (step_pulse)
    );

    // Hold reset for two cycles and release it on a falling edge; the next rising edge is cycle 1.
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        run = 1'b0; mode = 2'd0; speed = 3'd0;
        rst = 1'b1;
        #2;
        repeat (3) @(negedge clk);
        n_total++;
        if (led !== 5'b00001) $display("FAIL reset_led got %b exp %b", led, 5'b00001);
        else n_pass++;
        n_total++;
        if (step_pulse !== 1'b0) $display("FAIL reset_step got %b exp %b", step_pulse, 1'b0);
        else n_pass++;
        n_total++;
        if (led_en !== 5'b11111) $display("FAIL reset_led_en got %b exp %b", led_en, 5'b11111);
        else n_pass++;
        n_total++;
        if (clk_en !== 1'b1) $display("FAIL reset_clk_en got %b exp %b", clk_en, 1'b1);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_chase_up();
        logic [N-1:0] tbl [6];
        logic [N-1:0] exp_led;
        logic         exp_step;
        tbl = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        mode = 2'd0; speed = 3'd0; run = 1'b1;
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            exp_led  = tbl[(k - 1) / 4];
            exp_step = (k >= 5) && (((k - 1) % 4) == 0);
            n_total++;
            if (led !== exp_led) $display("FAIL chase_up_led cycle %0d got %b exp %b", k, led, exp_led);
            else n_pass++;
            n_total++;
            if (step_pulse !== exp_step) $display("FAIL chase_up_step cycle %0d got %b exp %b", k, step_pulse, exp_step);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        logic [N-1:0] tbl [9];
        logic [N-1:0] exp_led;
        logic         exp_step;
        tbl = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000,
                5'b01000, 5'b00100, 5'b00010, 5'b00001};
        mode = 2'd2; speed = 3'd1; run = 1'b1;
        do_reset();
        for (int k = 1; k <= 72; k++) begin
            @(negedge clk);
            exp_led  = tbl[(k - 1) / 8];
            exp_step = (k >= 9) && (((k - 1) % 8) == 0);
            n_total++;
            if (led !== exp_led) $display("FAIL bounce_led cycle %0d got %b exp %b", k, led, exp_led);
            else n_pass++;
            n_total++;
            if (step_pulse !== exp_step) $display("FAIL bounce_step cycle %0d got %b exp %b", k, step_pulse, exp_step);
            else n_pass++;
        end
    endtask

    // Blink from reset, then switch to chase down mid-period: ptr 0 wraps to 4.
    task automatic test_blink_then_down();
        logic [N-1:0] tbl [7];
        logic [N-1:0] exp_led;
        logic         exp_step;
        tbl = '{5'b00001, 5'b11111, 5'b00000, 5'b11111, 5'b10000, 5'b01000, 5'b00100};
        mode = 2'd3; speed = 3'd0; run = 1'b1;
        do_reset();
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            exp_led  = tbl[(k - 1) / 4];
            exp_step = (k >= 5) && (((k - 1) % 4) == 0);
            n_total++;
            if (led !== exp_led) $display("FAIL blink_down_led cycle %0d got %b exp %b", k, led, exp_led);
            else n_pass++;
            n_total++;
            if (step_pulse !== exp_step) $display("FAIL blink_down_step cycle %0d got %b exp %b", k, step_pulse, exp_step);
            else n_pass++;
            if (k == 14) mode = 2'd1;
        end
    endtask

    task automatic test_pause();
        mode = 2'd0; speed = 3'd1; run = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        run = 1'b0;
        for (int k = 4; k <= 23; k++) begin
            @(negedge clk);
            n_total++;
            if (step_pulse !== 1'b0 || led !== 5'b00001)
                $display("FAIL pause_hold cycle %0d got step=%b led=%b exp step=0 led=00001", k, step_pulse, led);
            else n_pass++;
        end
        run = 1'b1;
        repeat (5) @(negedge clk);
        n_total++;
        if (step_pulse !== 1'b0 || led !== 5'b00001)
            $display("FAIL pause_before_tick got step=%b led=%b exp step=0 led=00001", step_pulse, led);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (step_pulse !== 1'b1 || led !== 5'b00010)
            $display("FAIL pause_resume_tick got step=%b led=%b exp step=1 led=00010", step_pulse, led);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (step_pulse !== 1'b0) $display("FAIL pause_pulse_width got %b exp %b", step_pulse, 1'b0);
        else n_pass++;
    endtask

    // Shortening the period below the current count must fire on the very next cycle.
    task automatic test_speed_drop();
        mode = 2'd0; speed = 3'd7; run = 1'b1;
        do_reset();
        repeat (10) @(negedge clk);
        speed = 3'd0;
        @(negedge clk);
        n_total++;
        if (step_pulse !== 1'b0 || led !== 5'b00001)
            $display("FAIL speed_drop_pre got step=%b led=%b exp step=0 led=00001", step_pulse, led);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (step_pulse !== 1'b1 || led !== 5'b00010)
            $display("FAIL speed_drop_tick got step=%b led=%b exp step=1 led=00010", step_pulse, led);
        else n_pass++;
        repeat (4) @(negedge clk);
        n_total++;
        if (step_pulse !== 1'b1 || led !== 5'b00100)
            $display("FAIL speed_drop_next got step=%b led=%b exp step=1 led=00100", step_pulse, led);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        mode = 2'd2; speed = 3'd0; run = 1'b1;
        do_reset();
        repeat (21) @(negedge clk);
        n_total++;
        if (led !== 5'b01000 || step_pulse !== 1'b1)
            $display("FAIL async_pre got step=%b led=%b exp step=1 led=01000", step_pulse, led);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (led !== 5'b00001 || step_pulse !== 1'b0)
            $display("FAIL async_immediate got step=%b led=%b exp step=0 led=00001", step_pulse, led);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_total++;
        if (led !== 5'b00001 || step_pulse !== 1'b0)
            $display("FAIL async_after_pre got step=%b led=%b exp step=0 led=00001", step_pulse, led);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (led !== 5'b00010 || step_pulse !== 1'b1)
            $display("FAIL async_first_tick got step=%b led=%b exp step=1 led=00010", step_pulse, led);
        else n_pass++;
    endtask

`ifdef LED_PWM_DIM_EN
    task automatic test_pwm_dim();
        int on_cnt;
        int other_cnt;
        mode = 2'd0; speed = 3'd0; run = 1'b0; brightness = 8'd64;
        do_reset();
        on_cnt = 0; other_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (led[0] === 1'b1) on_cnt++;
            if (led[4:1] !== 4'b0000) other_cnt++;
        end
        n_total++;
        if (on_cnt !== 64) $display("FAIL pwm_duty_64 got %0d exp %0d", on_cnt, 64);
        else n_pass++;
        n_total++;
        if (other_cnt !== 0) $display("FAIL pwm_inactive_leds got %0d exp %0d", other_cnt, 0);
        else n_pass++;
        brightness = 8'd0;
        repeat (2) @(negedge clk);
        on_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (led !== 5'b00000) on_cnt++;
        end
        n_total++;
        if (on_cnt !== 0) $display("FAIL pwm_duty_0 got %0d exp %0d", on_cnt, 0);
        else n_pass++;
    endtask
`endif

    initial begin
`ifdef LED_PWM_DIM_EN
        brightness = 8'd0;
`endif
        test_reset();
`ifdef LED_PWM_DIM_EN
        test_pwm_dim();
`else
        test_chase_up();
        test_bounce();
        test_blink_then_down();
        test_pause();
        test_speed_drop();
        test_async_reset();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
